// File: rtl/dbf_pkg.sv
// Shared constants and types for the digital beamformer channel summer.
// Holds sample widths, reset weight and accumulator width derivation.
package dbf_pkg;

    localparam int CH_NUM_DEF = 8;
    localparam int SMP_W      = 16;
    localparam int PROD_W     = 2 * SMP_W;
    localparam int SUM_W      = PROD_W + 1;

    localparam logic signed [SMP_W-1:0] W_RST_I = 16'sh7fff;
    localparam logic signed [SMP_W-1:0] W_RST_Q = 16'sh0000;

    // Accumulator wide enough that CH_NUM full-scale sums never overflow.
    function automatic int acc_w(input int ch_num);
        return SUM_W + $clog2(ch_num);
    endfunction

    typedef struct packed {
        logic first;
        logic last;
    } ctl_t;

endpackage

// File: rtl/dbf_cmult.sv
// Two-stage registered complex multiplier with valid/tag passthrough.
// Stage 1 registers the four partial products, stage 2 the complex sums.
module dbf_cmult
    import dbf_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  ctl_t                    in_ctl,
    input  logic signed [SMP_W-1:0] di,
    input  logic signed [SMP_W-1:0] dq,
    input  logic signed [SMP_W-1:0] wi,
    input  logic signed [SMP_W-1:0] wq,
    output logic                    out_valid,
    output ctl_t                    out_ctl,
    output logic signed [SUM_W-1:0] pi,
    output logic signed [SUM_W-1:0] pq
);

    logic                     p_v;
    ctl_t                     p_ctl;
    logic signed [PROD_W-1:0] p_ii;
    logic signed [PROD_W-1:0] p_qq;
    logic signed [PROD_W-1:0] p_iq;
    logic signed [PROD_W-1:0] p_qi;

    // Product stage: full-precision signed 16x16 products.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_v   <= 1'b0;
            p_ctl <= '0;
            p_ii  <= '0;
            p_qq  <= '0;
            p_iq  <= '0;
            p_qi  <= '0;
        end else begin
            p_v   <= in_valid;
            p_ctl <= in_ctl;
            p_ii  <= di * wi;
            p_qq  <= dq * wq;
            p_iq  <= di * wq;
            p_qi  <= dq * wi;
        end
    end

    // Sum stage: one extra bit so -32768^2 + -32768^2 cannot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ctl   <= '0;
            pi        <= '0;
            pq        <= '0;
        end else begin
            out_valid <= p_v;
            out_ctl   <= p_ctl;
            pi <= $signed({p_ii[PROD_W-1], p_ii})
                - $signed({p_qq[PROD_W-1], p_qq});
            pq <= $signed({p_iq[PROD_W-1], p_iq})
                + $signed({p_qi[PROD_W-1], p_qi});
        end
    end

endmodule

// File: rtl/dbf_ch_sum.sv
// Beamformer channel summer: weights each channel and accumulates a beam.
// Channel counter, weight bank, accumulator and output truncation live here.
module dbf_ch_sum
    import dbf_pkg::*;
#(
    parameter int CH_NUM = CH_NUM_DEF,
    parameter int LEN    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [SMP_W-1:0]   data_i,
    input  logic signed [SMP_W-1:0]   data_q,
    input  logic                      in_valid,
    input  logic                      in_first,
    input  logic                      w_wr_en,
    input  logic [$clog2(CH_NUM)-1:0] w_addr,
    input  logic signed [SMP_W-1:0]   w_i,
    input  logic signed [SMP_W-1:0]   w_q,
    output logic signed [LEN-1:0]     data_out_i,
    output logic signed [LEN-1:0]     data_out_q,
    output logic                      out_valid,
    output logic                      ch_err
);

    localparam int CW    = $clog2(CH_NUM);
    localparam int ACC_W = acc_w(CH_NUM);
    localparam int EXT_W = ACC_W - SUM_W;

    logic [CW-1:0]           ch;
    logic [CW-1:0]           cur_ch;
    logic signed [SMP_W-1:0] wt_i [CH_NUM];
    logic signed [SMP_W-1:0] wt_q [CH_NUM];

    logic                    s0_v;
    ctl_t                    s0_ctl;
    logic signed [SMP_W-1:0] s0_di;
    logic signed [SMP_W-1:0] s0_dq;
    logic signed [SMP_W-1:0] s0_wi;
    logic signed [SMP_W-1:0] s0_wq;

    logic                    m_v;
    ctl_t                    m_ctl;
    logic signed [SUM_W-1:0] m_pi;
    logic signed [SUM_W-1:0] m_pq;

    logic signed [ACC_W-1:0] acc_i;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_i_nxt;
    logic signed [ACC_W-1:0] acc_q_nxt;

    assign cur_ch = in_first ? '0 : ch;

    // Weight bank; the sampling stage reads the pre-write value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CH_NUM; k++) begin
                wt_i[k] <= W_RST_I;
                wt_q[k] <= W_RST_Q;
            end
        end else if (w_wr_en) begin
            wt_i[w_addr] <= w_i;
            wt_q[w_addr] <= w_q;
        end
    end

    // Channel tracking, resync detection and sample/weight capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch     <= '0;
            ch_err <= 1'b0;
            s0_v   <= 1'b0;
            s0_ctl <= '0;
            s0_di  <= '0;
            s0_dq  <= '0;
            s0_wi  <= '0;
            s0_wq  <= '0;
        end else begin
            ch_err <= in_valid & in_first & (ch != '0);
            s0_v   <= in_valid;
            if (in_valid) begin
                ch <= (cur_ch == CW'(CH_NUM - 1)) ? '0 : cur_ch + 1'b1;
                s0_ctl.first <= (cur_ch == '0);
                s0_ctl.last  <= (cur_ch == CW'(CH_NUM - 1));
                s0_di <= data_i;
                s0_dq <= data_q;
                s0_wi <= wt_i[cur_ch];
                s0_wq <= wt_q[cur_ch];
            end
        end
    end

    dbf_cmult u_cmult (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s0_v),
        .in_ctl    (s0_ctl),
        .di        (s0_di),
        .dq        (s0_dq),
        .wi        (s0_wi),
        .wq        (s0_wq),
        .out_valid (m_v),
        .out_ctl   (m_ctl),
        .pi        (m_pi),
        .pq        (m_pq)
    );

    // Channel 0 restarts the sum, which also discards an aborted frame.
    always_comb begin
        acc_i_nxt = {{EXT_W{m_pi[SUM_W-1]}}, m_pi};
        acc_q_nxt = {{EXT_W{m_pq[SUM_W-1]}}, m_pq};
        if (!m_ctl.first) begin
            acc_i_nxt = acc_i + acc_i_nxt;
            acc_q_nxt = acc_q + acc_q_nxt;
        end
    end

    // Accumulate and publish the truncated top LEN bits on the last channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_i      <= '0;
            acc_q      <= '0;
            data_out_i <= '0;
            data_out_q <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (m_v) begin
                acc_i <= acc_i_nxt;
                acc_q <= acc_q_nxt;
                if (m_ctl.last) begin
                    data_out_i <= acc_i_nxt[ACC_W-1 -: LEN];
                    data_out_q <= acc_q_nxt[ACC_W-1 -: LEN];
                    out_valid  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dbf_ch_sum.sv
// Scoreboard bench for dbf_ch_sum at default parameters.
// Stimulus pushes expected beams; a monitor pops them on out_valid.
module tb_dbf_ch_sum;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] data_i = '0;
    logic signed [15:0] data_q = '0;
    logic               in_valid = 1'b0;
    logic               in_first = 1'b0;
    logic               w_wr_en = 1'b0;
    logic [2:0]         w_addr = '0;
    logic signed [15:0] w_i = '0;
    logic signed [15:0] w_q = '0;
    logic signed [31:0] data_out_i;
    logic signed [31:0] data_out_q;
    logic               out_valid;
    logic               ch_err;

    typedef struct {
        longint ei;
        longint eq;
        int     due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   errcnt = 0;

    dbf_ch_sum dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .data_q     (data_q),
        .in_valid   (in_valid),
        .in_first   (in_first),
        .w_wr_en    (w_wr_en),
        .w_addr     (w_addr),
        .w_i        (w_i),
        .w_q        (w_q),
        .data_out_i (data_out_i),
        .data_out_q (data_out_q),
        .out_valid  (out_valid),
        .ch_err     (ch_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, longint act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (ch_err) errcnt++;
        if (out_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out_valid: got 1 want 0 at cyc %0d", cyc);
            end else begin
                e = sb.pop_front();
                check("out_i", data_out_i, e.ei);
                check("out_q", data_out_q, e.eq);
                check("latency", cyc, e.due);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic signed [15:0] wi,
                      input logic signed [15:0] wq);
        w_wr_en = 1'b1;
        w_addr  = a;
        w_i     = wi;
        w_q     = wq;
        tick();
        w_wr_en = 1'b0;
    endtask

    task automatic send(input logic signed [15:0] di,
                        input logic signed [15:0] dq,
                        input logic first, output int n);
        data_i   = di;
        data_q   = dq;
        in_valid = 1'b1;
        in_first = first;
        tick();
        n        = cyc;
        in_valid = 1'b0;
        in_first = 1'b0;
        w_wr_en  = 1'b0;
    endtask

    task automatic frame(input logic signed [15:0] di,
                         input logic signed [15:0] dq,
                         input int gap, input logic wr7,
                         input logic signed [15:0] wi7,
                         input logic signed [15:0] wq7,
                         input longint ei, input longint eq);
        int n;
        for (int c = 0; c < 8; c++) begin
            if (c == 7 && wr7) begin
                w_wr_en = 1'b1;
                w_addr  = 3'd7;
                w_i     = wi7;
                w_q     = wq7;
            end
            send(di, dq, c == 0, n);
            if (c == 7) sb.push_back('{ei, eq, n + 3});
            idle(gap);
        end
    endtask

    task automatic partial(input logic signed [15:0] di,
                           input logic signed [15:0] dq, input int k);
        int n;
        for (int c = 0; c < k; c++) send(di, dq, c == 0, n);
    endtask

    initial begin
        idle(3);
        rst = 1'b0;
        check("rst_out_i", data_out_i, 0);
        check("rst_out_q", data_out_q, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_ch_err", ch_err, 0);

        frame(1000, 0, 0, 0, 0, 0, 16383500, 0);
        frame(-500, 250, 0, 0, 0, 0, -8191750, 4095875);
        frame(-1, -1, 0, 0, 0, 0, -16384, -16384);
        idle(8);
        check("hold_out_i", data_out_i, -16384);
        check("hold_out_q", data_out_q, -16384);

        partial(1000, 0, 5);
        frame(2000, 0, 0, 0, 0, 0, 32767000, 0);
        idle(6);
        check("ch_err_cnt", errcnt, 1);

        frame(1000, 0, 1, 1, 0, 0, 16383500, 0);
        idle(6);
        frame(1000, 0, 0, 0, 0, 0, 14335562, 0);
        idle(6);

        for (int k = 0; k < 8; k++) wr(k[2:0], 0, 0);
        wr(3'd3, 0, 32767);
        frame(1000, 0, 0, 0, 0, 0, 0, 2047937);
        idle(6);

        for (int k = 0; k < 8; k++) wr(k[2:0], -32768, -32768);
        frame(-32768, -32768, 0, 0, 0, 0, 0, 1073741824);
        idle(6);

        partial(1000, 0, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_i", data_out_i, 0);
        check("midrst_out_q", data_out_q, 0);
        check("midrst_out_valid", out_valid, 0);
        idle(8);
        frame(1000, 0, 0, 0, 0, 0, 16383500, 0);

        for (int k = 0; k < 50 && sb.size() > 0; k++) tick();
        idle(2);
        check("sb_drained", sb.size(), 0);
        check("ch_err_final", errcnt, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
